// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down counter with load, cascadable terminal
// count and a sticky wrap flag.
module prog_mod_counter #(
    parameter int N_WIDTH     = 4,
    parameter int MOD_DEFAULT = (1 << N_WIDTH),
    parameter int RESET_VAL   = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               up_dn,
    input  logic               load,
    input  logic [N_WIDTH-1:0] load_val,
    input  logic               mod_wr,
    input  logic [N_WIDTH-1:0] mod_val,
    input  logic               clr_wrapped,
    output logic [N_WIDTH-1:0] y,
    output logic               tc,
    output logic               wrapped,
    output logic [N_WIDTH-1:0] mod_q
);

    localparam int W1 = N_WIDTH + 1;
    localparam logic [N_WIDTH-1:0] MOD_RST = N_WIDTH'(MOD_DEFAULT);
    localparam logic [N_WIDTH-1:0] Y_RST   = N_WIDTH'(RESET_VAL);

    logic [N_WIDTH-1:0] y_q, y_d;
    logic [N_WIDTH-1:0] mod_d;
    logic               wrap_q, wrap_d;

    logic [W1-1:0]      m_cur, m_wr, m_ld;
    logic [N_WIDTH-1:0] m_cur_m1, m_ld_m1;
    logic               at_last, at_zero, wrap_ev;

    // A stored modulus of zero stands for 2^N_WIDTH; widen by one bit.
    function automatic logic [W1-1:0] decode(input logic [N_WIDTH-1:0] v);
        decode = (v == '0) ? {1'b1, {N_WIDTH{1'b0}}} : {1'b0, v};
    endfunction

    assign m_cur    = decode(mod_q);
    assign m_wr     = decode(mod_val);
    assign m_ld     = mod_wr ? m_wr : m_cur;
    assign m_cur_m1 = N_WIDTH'(m_cur - W1'(1));
    assign m_ld_m1  = N_WIDTH'(m_ld - W1'(1));

    assign at_last  = ({1'b0, y_q} == (m_cur - W1'(1)));
    assign at_zero  = (y_q == '0);

    // A wrap happens only on a plain enabled count at the boundary.
    assign wrap_ev  = en & ~load & ~mod_wr & (up_dn ? at_zero : at_last);
    assign tc       = wrap_ev & reset_n;

    // Next count: load beats modulus write beats counting.
    always_comb begin
        y_d = y_q;
        if (load) begin
            if ({1'b0, load_val} < m_ld) y_d = load_val;
            else                         y_d = m_ld_m1;
        end else if (mod_wr) begin
            if ({1'b0, y_q} >= m_wr) y_d = '0;
        end else if (en) begin
            if (up_dn) y_d = at_zero ? m_cur_m1 : y_q - N_WIDTH'(1);
            else       y_d = at_last ? '0 : y_q + N_WIDTH'(1);
        end
    end

    // Modulus and sticky flag next state; a wrap outranks a clear.
    always_comb begin
        mod_d  = mod_wr ? mod_val : mod_q;
        wrap_d = wrap_q;
        if (wrap_ev)          wrap_d = 1'b1;
        else if (clr_wrapped) wrap_d = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q    <= Y_RST;
            mod_q  <= MOD_RST;
            wrap_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            mod_q  <= mod_d;
            wrap_q <= wrap_d;
        end
    end

    assign y       = y_q;
    assign wrapped = wrap_q;

endmodule
